// File: rtl/maxima_list.sv
// Sorted top-DEPTH maxima store: inserts search results by shifting, streams and clears the list on frame end.
// Optional build macro MAXIMA_DEDUP_EN rejects candidates whose key matches a neighbouring stored key.
module maxima_list #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 25,
  parameter int KEY_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ins_valid,
  output logic                         ins_ready,
  input  logic [WIDTH-1:0]             ins_data,
  input  logic [4:0]                   ins_index,
  input  logic                         frame_end,
  output logic [DEPTH-1:0][WIDTH-1:0]  maximas,
  output logic [4:0]                   count,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_last,
  output logic [2:0]                   state_dbg
);
  // Handshakes: a beat transfers on the rising edge where valid && ready are both high;
  // out_valid/out_data hold steady while out_ready is low.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = 5;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_WRITE = 3'd2,
    S_DUMP  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t state, state_n;

  logic [PW-1:0]    p, p_m1, idx_r, idx_w, rd;
  logic [WIDTH-1:0] data_r;
  logic             dump_pend;
  logic [CW-1:0]    idx_sel, rd_ext;
  logic             reject_c, dup_c, accept;

  assign state_dbg = state;
  assign p_m1      = p - PW'(1);
  assign idx_sel   = (ins_index < count) ? ins_index : count;
  assign idx_w     = idx_sel[PW-1:0];
  assign reject_c  = (ins_index >= DEPTH_C);
  assign rd_ext    = {{(CW-PW){1'b0}}, rd};
  assign out_data  = maximas[rd];

  always_comb begin
    dup_c = 1'b0;
`ifdef MAXIMA_DEDUP_EN
    if ((idx_sel < count) && (maximas[idx_w][KEY_W-1:0] == ins_data[KEY_W-1:0]))
      dup_c = 1'b1;
    if ((idx_w != '0) && (maximas[idx_w - PW'(1)][KEY_W-1:0] == ins_data[KEY_W-1:0]))
      dup_c = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    ins_ready = 1'b0;
    accept    = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      S_IDLE: begin
        ins_ready = !dump_pend && !frame_end;
        if (frame_end || dump_pend) begin
          state_n = S_DUMP;
        end else if (ins_valid && !reject_c && !dup_c) begin
          accept  = 1'b1;
          state_n = (idx_sel == DEPTH_C - CW'(1)) ? S_WRITE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (p_m1 == idx_r) state_n = S_WRITE;
      end
      S_WRITE: begin
        // A frame_end landing on the write cycle itself is folded in here.
        state_n = (dump_pend || frame_end) ? S_DUMP : S_IDLE;
      end
      S_DUMP: begin
        out_valid = (rd_ext < count);
        out_last  = out_valid && (rd_ext == count - CW'(1));
        if (count == '0)                          state_n = S_CLEAR;
        else if (out_valid && out_ready && out_last) state_n = S_CLEAR;
      end
      S_CLEAR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      maximas   <= '0;
      count     <= '0;
      p         <= PW'(DEPTH-1);
      idx_r     <= '0;
      data_r    <= '0;
      rd        <= '0;
      dump_pend <= 1'b0;
    end else begin
      if ((state == S_SHIFT || state == S_WRITE) && frame_end)
        dump_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            data_r <= ins_data;
            idx_r  <= idx_w;
            p      <= PW'(DEPTH-1);
          end
        end
        S_SHIFT: begin
          maximas[p] <= maximas[p_m1];
          p          <= p_m1;
        end
        S_WRITE: begin
          maximas[idx_r] <= data_r;
          if (count != DEPTH_C) count <= count + CW'(1);
        end
        S_DUMP: begin
          if (out_valid && out_ready) rd <= rd + PW'(1);
        end
        S_CLEAR: begin
          maximas   <= '0;
          count     <= '0;
          rd        <= '0;
          dump_pend <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_maxima_list.sv
// Self-checking bench for maxima_list: queue-based reference list, readout scoreboard, directed and random inserts.
module tb_maxima_list;
  localparam int DEPTH = 16;
  localparam int WIDTH = 25;
  localparam int KEY_W = 16;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        ins_valid = 1'b0;
  logic                        ins_ready;
  logic [WIDTH-1:0]            ins_data = '0;
  logic [4:0]                  ins_index = '0;
  logic                        frame_end = 1'b0;
  logic [DEPTH-1:0][WIDTH-1:0] maximas;
  logic [4:0]                  count;
  logic                        out_valid;
  logic                        out_ready = 1'b1;
  logic [WIDTH-1:0]            out_data;
  logic                        out_last;
  logic [2:0]                  state_dbg;

  maxima_list #(.DEPTH(DEPTH), .WIDTH(WIDTH), .KEY_W(KEY_W)) dut (
    .clk(clk), .reset(reset), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_data(ins_data), .ins_index(ins_index), .frame_end(frame_end),
    .maximas(maximas), .count(count), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_last_q[$];
  logic [WIDTH-1:0] ml[$];
  int rdy_mode = 0;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int pk = 0;
  logic             held_v = 1'b0;
  logic [WIDTH-1:0] held_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] mexp(int j);
    return (j < ml.size()) ? ml[j] : '0;
  endfunction

  function automatic logic [WIDTH-1:0] mk(int key);
    logic [8:0] u;
    u = 9'($urandom);
    return {u, 16'(key)};
  endfunction

  function automatic int sorted_pos(int key);
    for (int i = 0; i < ml.size(); i++)
      if (int'(ml[i][KEY_W-1:0]) < key) return i;
    return ml.size();
  endfunction

  // Returns expected cycles until ins_ready is back (0 for a drop).
  function automatic int model_insert(logic [WIDTH-1:0] d, int index);
    int idx;
    if (index >= DEPTH) return 0;
    idx = (index < ml.size()) ? index : ml.size();
`ifdef MAXIMA_DEDUP_EN
    if (idx < ml.size() && ml[idx][KEY_W-1:0] == d[KEY_W-1:0]) return 0;
    if (idx > 0 && ml[idx-1][KEY_W-1:0] == d[KEY_W-1:0]) return 0;
`endif
    ml.insert(idx, d);
    if (ml.size() > DEPTH) void'(ml.pop_back());
    return DEPTH - idx;
  endfunction

  task automatic push_frame();
    for (int i = 0; i < ml.size(); i++) begin
      exp_q.push_back(ml[i]);
      exp_last_q.push_back(i == ml.size() - 1);
    end
    ml.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_array();
    int j;
    j = 0;
    for (int i = 0; i < DEPTH; i++)
      if (maximas[i] !== mexp(i)) begin j = i; break; end
    chk("maximas", 32'(maximas[j]), 32'(mexp(j)));
    chk("count", 32'(count), 32'(ml.size()));
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ins_ready && n < 400) begin @(posedge clk); #1; n++; end
    if (n >= 400) chk(name, 0, 1);
  endtask

  task automatic do_insert(input logic [WIDTH-1:0] d, input int index, input int fe_at);
    int lat, elat;
    wait_ready("ready_before_insert");
    ins_valid = 1'b1; ins_data = d; ins_index = 5'(index);
    @(posedge clk); #1;
    ins_valid = 1'b0;
    elat = model_insert(d, index);
    lat = 0;
    while (!ins_ready && lat < 400) begin
      if (fe_at != 0 && lat == fe_at) begin frame_end = 1'b1; push_frame(); end
      @(posedge clk); #1;
      frame_end = 1'b0;
      lat++;
    end
    if (lat >= 400) chk("insert_timeout", 32'(lat), 0);
    if (fe_at == 0) chk("latency", 32'(lat), 32'(elat));
    check_array();
  endtask

  task automatic do_frame(input bit with_ins);
    wait_ready("ready_before_frame");
    frame_end = 1'b1;
    ins_valid = with_ins; ins_data = mk(999); ins_index = 5'd0;
    #1;
    chk("ins_ready_on_frame_end", 32'(ins_ready), 0);
    push_frame();
    @(posedge clk); #1;
    frame_end = 1'b0; ins_valid = 1'b0;
    wait_ready("dump_done");
    check_array();
  endtask

  // ---------------- out_ready driver ----------------
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = pat[pk % 4]; pk++; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (held_v) chk("hold_data", 32'(out_data), 32'(held_d));
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: out_data %0d with no expected entry at %0t", out_data, $time);
        end else if (out_ready) begin
          chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
          chk("out_last", 32'(out_last), 32'(exp_last_q.pop_front()));
        end
        held_v = !out_ready;
        held_d = out_data;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ins_ready", 32'(ins_ready), 1);
    chk("rst_state", 32'(state_dbg), 0);
    check_array();

    do_insert(mk(100), 0, 0);
    do_insert(mk(300), 0, 0);
    do_insert(mk(200), 1, 0);
    do_frame(1'b0);

    do_insert(mk(100), 0, 0);
    do_insert(mk(200), 0, 0);
    do_insert(mk(300), 0, 3);

    for (int i = 0; i < DEPTH; i++) do_insert(mk(160 - 10 * i), i, 0);
    do_insert(mk(155), 1, 0);
    do_insert(mk(77), 16, 0);
    do_insert(mk(77), 20, 0);

    rdy_mode = 1;
    do_frame(1'b1);
    rdy_mode = 0;
    do_frame(1'b0);

    do_insert(mk(200), 0, 0);
    do_insert(mk(200), 0, 0);
    do_insert(mk(50), 5, 0);
    do_frame(1'b0);

    do_insert(mk(40), 0, 0);
    do_insert(mk(30), 1, 0);
    wait_ready("ready_before_reset_test");
    ins_valid = 1'b1; ins_data = mk(90); ins_index = 5'd0;
    @(posedge clk); #1;
    ins_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    ml.delete();
    check_array();
    chk("rst_mid_shift_state", 32'(state_dbg), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(ins_ready), 1);

    rdy_mode = 2;
    for (int n = 0; n < 300; n++) begin
      int key, idx;
      if ($urandom_range(0, 15) == 0) begin
        do_frame(1'($urandom_range(0, 1)));
      end else begin
        key = $urandom_range(0, 400);
        idx = ($urandom_range(0, 3) != 0) ? sorted_pos(key) : $urandom_range(0, 20);
        do_insert(mk(key), idx, 0);
      end
    end
    do_frame(1'b0);

    repeat (5) @(posedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maxima_list.md
# maxima_list

Sorted storage stage directly downstream of the binary search in the find_maximas path. It holds the running top-DEPTH spectral maxima of the current frame in descending key order and accepts (candidate, insert position) pairs from the search. For each accepted pair it shifts the lower entries down one slot per cycle and writes the candidate. On frame end it streams the list out, clears it, and feeds the live array back to the search as its compare table.

## Interface
- DEPTH, 16: number of maxima kept; fixed power of two, ≤ 16.
- WIDTH, 25: entry width.
- KEY_W, 16: compare key, entry bits [KEY_W-1:0].

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ins_valid  in  1  candidate pair valid.
- ins_ready  out  1  block can accept a pair this cycle.
- ins_data  in  WIDTH  candidate value.
- ins_index  in  5  insert slot 0..DEPTH-1; values ≥ DEPTH mean reject.
- frame_end  in  1  single-cycle pulse marking end of frame.
- maximas  out  WIDTH×DEPTH  registered entry array, index 0 largest.
- count  out  5  valid entries, 0..DEPTH.
- out_valid / out_ready  out / in  1 each  readout handshake.
- out_data  out  WIDTH  readout entry.
- out_last  out  1  marks the final readout beat.

## Operation
- States:
  - S_IDLE: ins_ready = (state == S_IDLE) && !dump_pend && !frame_end.
  - S_SHIFT
  - S_WRITE
  - S_DUMP
  - S_CLEAR
- Accept: ins_valid && ins_ready. Latch data and idx, where idx = min(ins_index, count).
  - ins_index ≥ DEPTH: drop the pair and stay in S_IDLE; count is unchanged.
  - Otherwise set p = DEPTH-1.
    - If p == idx, go to S_WRITE.
    - Else go to S_SHIFT.
- S_SHIFT, each cycle:
  - entries[p] <= entries[p-1]; p <= p-1.
  - When the new p equals idx, go to S_WRITE.
  - The old entries[DEPTH-1] is discarded.
- S_WRITE:
  - entries[idx] <= data.
  - count <= min(count+1, DEPTH).
  - Next state is S_DUMP if dump_pend is set, else S_IDLE.
- frame_end:
  - In S_IDLE: go to S_DUMP with rd = 0.
  - In any other state: set dump_pend; it is serviced after the current insert completes.
  - In S_DUMP or S_CLEAR: ignored.
- S_DUMP:
  - out_valid = (rd < count); out_data = entries[rd]; out_last = (rd == count-1).
  - rd advances on out_valid && out_ready.
  - After the out_last beat, or immediately if count == 0, go to S_CLEAR.
- S_CLEAR: all entries <= 0, count <= 0, dump_pend <= 0; then S_IDLE.
- Ordering is non-increasing by key. Equal keys are allowed; the newer value goes at idx, above older equal entries.

## Timing
- Reset values:
  - State: S_IDLE.
  - Outputs: all entries 0, count 0, out_valid 0, out_last 0.
  - ins_ready is 1 one cycle after reset is released (state S_IDLE).
  - Internal: dump_pend 0, rd 0, p DEPTH-1.
- Insert latency from the accept edge: (DEPTH-1-idx) shift cycles + 1 write cycle. For DEPTH = 16 that is 1 cycle at idx 15 and 16 cycles at idx 0.
- maximas and count update on the edge that closes S_WRITE. Between accept and that edge the search must not start, which ins_ready enforces.
- Reject: 1 cycle, with ins_ready high again on the next cycle.
- frame_end arriving in the same cycle as ins_valid: frame_end wins. ins_ready is 0 and the pair is not accepted.
- Readout: one beat per cycle under continuous out_ready. out_data/out_valid stay stable while out_ready is low.
- Reset asserted mid-shift or mid-dump: immediate return to reset values; the partial shift is discarded.

## Configuration
- MAXIMA_DEDUP_EN defined:
  - At accept, the candidate is dropped as a 1-cycle reject if its key equals the key of entries[idx] or entries[idx-1] (idx > 0) among valid entries.
  - Prevents duplicate peaks from repeated bins.
- Undefined: equal keys are inserted per the normal rules.

## Test plan
- Reset, then insert keys 100, 300, 200 with indices 0, 0, 1 → maximas[0..2] = 300, 200, 100; count = 3; latencies 16, 16, 15 cycles.
- Fill with 16 descending keys 160..10 step −10, then insert key 155 at idx 1 → key 10 is dropped, maximas[1] = 155, count stays 16.
- ins_index = 16 with count = 16 → single-cycle reject, array unchanged, ins_ready high the next cycle.
- frame_end pulsed during an idx-0 shift → the insert completes, then 3 readout beats 300/200/100 with out_last on the third, then S_CLEAR; count = 0 and all maximas are 0.
- Readout with out_ready toggling 1,0,0,1 → out_data is held during stalls and no beat is lost or duplicated. Separately, frame_end with count = 0 → out_valid is never asserted and the block returns to S_IDLE after S_CLEAR.
- MAXIMA_DEDUP_EN defined, insert key 200 twice at the same idx → the second is rejected and count is unchanged. With the macro undefined, both are stored.
